// File: rtl/wait_timer_arbiter.sv
// Round-robin arbiter for one shared wait/timeout counter.
// The winner's duration is latched at grant; the owner may abort, otherwise done pulses on expiry.
module wait_timer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           cancel,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] wait_cycles,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         cur_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] dlat_q, dlat_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   elig_s;
  logic                 found_s;
  int                   win_s;
  logic [CNT_WIDTH-1:0] dur_s;

  // Next-state, arbitration and counter logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    grant_d = grant_q;
    done_d  = {NUM_REQ{1'b0}};

    // A requester whose done is showing cannot win again in that same cycle.
    if (state_q == DONE) begin
      elig_s = req & ~cancel & ~done_q;
    end else begin
      elig_s = req & ~cancel;
    end

    found_s = 1'b0;
    win_s   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found_s && elig_s[(int'(ptr_q) + k) % NUM_REQ]) begin
        found_s = 1'b1;
        win_s   = (int'(ptr_q) + k) % NUM_REQ;
      end else begin
        found_s = found_s;
      end
    end
    dur_s = wait_cycles[win_s*CNT_WIDTH +: CNT_WIDTH];

    case (state_q)
      IDLE, DONE: begin
        if (found_s) begin
          state_d = COUNT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
          ptr_d   = PTR_W'(win_s);
          cnt_d   = {CNT_WIDTH{1'b0}};
          dlat_d  = (dur_s == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : dur_s;
        end else begin
          state_d = IDLE;
          grant_d = {NUM_REQ{1'b0}};
          cnt_d   = {CNT_WIDTH{1'b0}};
        end
      end
      COUNT: begin
        // Owner abort takes priority over a terminal count in the same cycle.
        if (cancel[ptr_q]) begin
          state_d = IDLE;
          grant_d = {NUM_REQ{1'b0}};
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else if (cnt_q == dlat_q - CNT_WIDTH'(1)) begin
          state_d = DONE;
          grant_d = {NUM_REQ{1'b0}};
          done_d  = grant_q;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
        cnt_d   = {CNT_WIDTH{1'b0}};
      end
    endcase

    busy_d = |grant_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= {CNT_WIDTH{1'b0}};
      dlat_q  <= {CNT_WIDTH{1'b0}};
      grant_q <= {NUM_REQ{1'b0}};
      done_q  <= {NUM_REQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cur_count = cnt_q;

endmodule

// File: tb/tb_wait_timer_arbiter.sv
// Directed bench for wait_timer_arbiter: inputs driven and outputs checked on the falling edge.
module tb_wait_timer_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   cancel;
  logic [N*W-1:0] wait_cycles;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cur_count;

  int n_err = 0;
  int n_chk = 0;

  wait_timer_arbiter #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .cancel      (cancel),
    .wait_cycles (wait_cycles),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .cur_count   (cur_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_d(input int i, input int d);
    wait_cycles[i*W +: W] = W'(d);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_done"},  32'(done),  32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h0);
    chk({tag, "_cnt"},   32'(cur_count), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    cancel      = '0;
    wait_cycles = '0;
    tick();
    tick();
    idle_chk("reset");
    rst_n = 1'b1;
    tick();

    // Single wait: requester 2, D=5
    set_d(2, 5);
    req = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_cnt",   32'(cur_count), 32'(i));
      chk("single_busy",  32'(busy), 32'h1);
      chk("single_nodone", 32'(done), 32'h0);
      tick();
    end
    chk("single_done",    32'(done),  32'h4);
    chk("single_dgrant",  32'(grant), 32'h0);
    chk("single_dbusy",   32'(busy),  32'h0);
    req = 4'b0000;
    tick();
    idle_chk("single_after");

    // Round robin from a fresh pointer: order 0,1,2,3,0, period 4
    do_reset();
    for (int i = 0; i < N; i++) set_d(i, 3);
    req = 4'b1111;
    tick();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        chk("rr_grant", 32'(grant), 32'(1) << (r % 4));
        chk("rr_cnt",   32'(cur_count), 32'(c));
        chk("rr_nodone", 32'(done), 32'h0);
        tick();
      end
      chk("rr_done",   32'(done),  32'(1) << (r % 4));
      chk("rr_dgrant", 32'(grant), 32'h0);
      if (r == 4) req = 4'b0000;
      tick();
    end
    idle_chk("rr_after");

    // Cancel mid-wait: requester 1, D=10, cancel at count 4
    set_d(1, 10);
    req = 4'b0010;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("cxl_cnt", 32'(cur_count), 32'(i));
      tick();
    end
    chk("cxl_cnt4",  32'(cur_count), 32'h4);
    chk("cxl_grant", 32'(grant), 32'h2);
    cancel = 4'b0010;
    req    = 4'b0000;
    tick();
    cancel = 4'b0000;
    idle_chk("cxl_after");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cxl_nodone", 32'(done), 32'h0);
    end

    // Cancel on the terminal-count cycle: requester 3, D=4
    set_d(3, 4);
    req = 4'b1000;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("col_cnt", 32'(cur_count), 32'(i));
      tick();
    end
    chk("col_cnt3", 32'(cur_count), 32'h3);
    cancel = 4'b1000;
    req    = 4'b0000;
    tick();
    cancel = 4'b0000;
    idle_chk("col_after");
    tick();
    chk("col_nodone", 32'(done), 32'h0);

    // D=0 behaves as D=1
    set_d(3, 0);
    req = 4'b1000;
    tick();
    chk("d0_grant", 32'(grant), 32'h8);
    chk("d0_cnt",   32'(cur_count), 32'h0);
    req = 4'b0000;
    tick();
    chk("d0_done",   32'(done),  32'h8);
    chk("d0_dgrant", 32'(grant), 32'h0);
    tick();
    idle_chk("d0_after");

    // Duration latched at grant; owner dropping req is ignored
    set_d(0, 6);
    req = 4'b0001;
    tick();
    chk("latch_cnt0", 32'(cur_count), 32'h0);
    tick();
    chk("latch_cnt1", 32'(cur_count), 32'h1);
    set_d(0, 2);
    req = 4'b0000;
    tick();
    for (int i = 2; i < 6; i++) begin
      chk("latch_grant", 32'(grant), 32'h1);
      chk("latch_cnt",   32'(cur_count), 32'(i));
      tick();
    end
    chk("latch_done",   32'(done),  32'h1);
    chk("latch_dgrant", 32'(grant), 32'h0);
    tick();
    idle_chk("latch_after");

    // Async reset mid-count, then restart from requester 0's position
    set_d(2, 20);
    req = 4'b0100;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("ar_cnt7", 32'(cur_count), 32'h7);
    chk("ar_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk("ar_async");
    tick();
    idle_chk("ar_held");
    set_d(1, 2);
    set_d(3, 2);
    req   = 4'b1010;
    rst_n = 1'b1;
    tick();
    chk("ar_g1",   32'(grant), 32'h2);
    tick();
    chk("ar_g1c1", 32'(cur_count), 32'h1);
    tick();
    chk("ar_done1",  32'(done),  32'h2);
    chk("ar_dgrant", 32'(grant), 32'h0);
    req = 4'b1000;
    tick();
    chk("ar_g3",   32'(grant), 32'h8);
    chk("ar_nod",  32'(done),  32'h0);
    tick();
    tick();
    chk("ar_done3", 32'(done), 32'h8);
    req = 4'b0000;
    tick();
    idle_chk("ar_after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
